// File: rtl/ga_seq_if.sv
// ga_seq_if: handshake and status bundle between the GA sequencer and the
// phase modules / population register / host.
//   go                  : one-cycle run request from the host
//   <phase>_start/_done : one-cycle start pulse out, one-cycle done pulse back
//                         (phases: init, fit, sel, mut)
//   pop_load_init/_mut  : one-cycle population register load enables
//   gen_count           : generations committed in the current run
//   busy/done/error     : run status; err_phase names the phase that timed out
// Optional (GA_EARLY_STOP_EN): fit_target_met in, early_stop out.
// modport master = sequencer side, modport slave = phase-module/host side.
interface ga_seq_if #(
  parameter int GEN_W = 16
);
  logic             go;
  logic             init_start;
  logic             init_done;
  logic             fit_start;
  logic             fit_done;
  logic             sel_start;
  logic             sel_done;
  logic             mut_start;
  logic             mut_done;
  logic             pop_load_init;
  logic             pop_load_mut;
  logic [GEN_W-1:0] gen_count;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_phase;
`ifdef GA_EARLY_STOP_EN
  logic             fit_target_met;
  logic             early_stop;

  modport master (
    input  go, init_done, fit_done, sel_done, mut_done, fit_target_met,
    output init_start, fit_start, sel_start, mut_start,
           pop_load_init, pop_load_mut, gen_count, busy, done, error,
           err_phase, early_stop
  );
  modport slave (
    output go, init_done, fit_done, sel_done, mut_done, fit_target_met,
    input  init_start, fit_start, sel_start, mut_start,
           pop_load_init, pop_load_mut, gen_count, busy, done, error,
           err_phase, early_stop
  );
`else
  modport master (
    input  go, init_done, fit_done, sel_done, mut_done,
    output init_start, fit_start, sel_start, mut_start,
           pop_load_init, pop_load_mut, gen_count, busy, done, error,
           err_phase
  );
  modport slave (
    output go, init_done, fit_done, sel_done, mut_done,
    input  init_start, fit_start, sel_start, mut_start,
           pop_load_init, pop_load_mut, gen_count, busy, done, error,
           err_phase
  );
`endif
endinterface

// File: rtl/ga_sequencer.sv
// ga_sequencer: control-only scheduler for the genetic path-search engine.
// Runs one INIT phase, then NUM_GEN generations of FIT -> SEL -> MUT -> COMMIT.
// Each phase gets a registered one-cycle start pulse on entry and is left on
// its matching done pulse; a per-phase watchdog moves to ERROR after TIMEOUT
// busy cycles without a done.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : ga_seq_if.master (starts, dones, load enables, go, run status)
// Optional feature macro: GA_EARLY_STOP_EN -- when defined, fit_target_met
// sampled with fit_done sends FIT straight to FINISH and sets early_stop.
module ga_sequencer #(
  parameter int NUM_GEN = 100,
  parameter int GEN_W   = 16,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  ga_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FIT, S_SEL, S_MUT, S_COMMIT, S_FINISH, S_ERROR
  } state_e;

  localparam logic [GEN_W-1:0] NUM_GEN_C = GEN_W'(NUM_GEN);
  localparam logic [TO_W-1:0]  TIMEOUT_C = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic [1:0]       err_phase_q, err_phase_d;
  logic             init_start_q, init_start_d;
  logic             fit_start_q, fit_start_d;
  logic             sel_start_q, sel_start_d;
  logic             mut_start_q, mut_start_d;
  logic             pop_load_init_q, pop_load_init_d;
  logic             pop_load_mut_q, pop_load_mut_d;
`ifdef GA_EARLY_STOP_EN
  logic             early_stop_q, early_stop_d;
`endif

  logic             wd_expired;
  logic [GEN_W-1:0] gen_inc;

  // Comparing against TIMEOUT-1 before incrementing lets TIMEOUT use the full
  // counter range without wrapping; the cycle on which this is true is the
  // TIMEOUT-th busy cycle of the phase.
  assign wd_expired = (wd_q == TIMEOUT_C - TO_W'(1));
  assign gen_inc    = gen_q + GEN_W'(1);

  // NOTE: every variable gets its default before the case so that no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d         = state_q;
    gen_d           = gen_q;
    wd_d            = wd_q;
    err_phase_d     = err_phase_q;
    init_start_d    = 1'b0;
    fit_start_d     = 1'b0;
    sel_start_d     = 1'b0;
    mut_start_d     = 1'b0;
    pop_load_init_d = 1'b0;
    pop_load_mut_d  = 1'b0;
`ifdef GA_EARLY_STOP_EN
    early_stop_d    = early_stop_q;
`endif

    case (state_q)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (bus.go) begin
          state_d      = S_INIT;
          gen_d        = '0;
          wd_d         = '0;
          init_start_d = 1'b1;
`ifdef GA_EARLY_STOP_EN
          early_stop_d = 1'b0;
`endif
        end
      end

      // In every phase state the done input is tested first, so a done on the
      // watchdog's last cycle still wins over the timeout.
      S_INIT: begin
        if (bus.init_done) begin
          state_d         = S_FIT;
          wd_d            = '0;
          fit_start_d     = 1'b1;
          pop_load_init_d = 1'b1;
        end else if (wd_expired) begin
          state_d     = S_ERROR;
          err_phase_d = 2'd0;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      S_FIT: begin
        if (bus.fit_done) begin
`ifdef GA_EARLY_STOP_EN
          if (bus.fit_target_met) begin
            state_d      = S_FINISH;
            early_stop_d = 1'b1;
          end else begin
            state_d     = S_SEL;
            wd_d        = '0;
            sel_start_d = 1'b1;
          end
`else
          state_d     = S_SEL;
          wd_d        = '0;
          sel_start_d = 1'b1;
`endif
        end else if (wd_expired) begin
          state_d     = S_ERROR;
          err_phase_d = 2'd1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      S_SEL: begin
        if (bus.sel_done) begin
          state_d     = S_MUT;
          wd_d        = '0;
          mut_start_d = 1'b1;
        end else if (wd_expired) begin
          state_d     = S_ERROR;
          err_phase_d = 2'd2;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      S_MUT: begin
        if (bus.mut_done) begin
          state_d        = S_COMMIT;
          pop_load_mut_d = 1'b1;
        end else if (wd_expired) begin
          state_d     = S_ERROR;
          err_phase_d = 2'd3;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end

      // One-cycle commit: pop_load_mut is high here (registered on MUT exit).
      // The counter never passes NUM_GEN even if it were already there.
      S_COMMIT: begin
        if (gen_q != NUM_GEN_C) begin
          gen_d = gen_inc;
        end
        if (gen_inc == NUM_GEN_C || gen_q == NUM_GEN_C) begin
          state_d = S_FINISH;
        end else begin
          state_d     = S_FIT;
          wd_d        = '0;
          fit_start_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      gen_q           <= '0;
      wd_q            <= '0;
      err_phase_q     <= 2'd0;
      init_start_q    <= 1'b0;
      fit_start_q     <= 1'b0;
      sel_start_q     <= 1'b0;
      mut_start_q     <= 1'b0;
      pop_load_init_q <= 1'b0;
      pop_load_mut_q  <= 1'b0;
`ifdef GA_EARLY_STOP_EN
      early_stop_q    <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      gen_q           <= gen_d;
      wd_q            <= wd_d;
      err_phase_q     <= err_phase_d;
      init_start_q    <= init_start_d;
      fit_start_q     <= fit_start_d;
      sel_start_q     <= sel_start_d;
      mut_start_q     <= mut_start_d;
      pop_load_init_q <= pop_load_init_d;
      pop_load_mut_q  <= pop_load_mut_d;
`ifdef GA_EARLY_STOP_EN
      early_stop_q    <= early_stop_d;
`endif
    end
  end

  assign bus.init_start    = init_start_q;
  assign bus.fit_start     = fit_start_q;
  assign bus.sel_start     = sel_start_q;
  assign bus.mut_start     = mut_start_q;
  assign bus.pop_load_init = pop_load_init_q;
  assign bus.pop_load_mut  = pop_load_mut_q;
  assign bus.gen_count     = gen_q;
  assign bus.err_phase     = err_phase_q;
  assign bus.busy          = !(state_q inside {S_IDLE, S_FINISH, S_ERROR});
  assign bus.done          = (state_q == S_FINISH);
  assign bus.error         = (state_q == S_ERROR);
`ifdef GA_EARLY_STOP_EN
  assign bus.early_stop    = early_stop_q;
`endif

endmodule

// File: tb/tb_ga_sequencer.sv
// Testbench for ga_sequencer. An automatic responder answers each start pulse
// with its done after a random latency and records the latency; the expected
// run length is the sum of (latency+1) over all phases plus one COMMIT cycle
// per generation. Pulse counts, status and watchdog timing are checked per
// scenario task.
module tb_ga_sequencer;
  localparam int NUM_GEN = 4;
  localparam int GEN_W   = 16;
  localparam int TIMEOUT = 10;
  localparam int TO_W    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ga_seq_if #(.GEN_W(GEN_W)) bus ();

  ga_sequencer #(
    .NUM_GEN(NUM_GEN), .GEN_W(GEN_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder / monitor state (phase index: 0 init, 1 fit, 2 sel, 3 mut)
  logic [3:0] starts;
  logic [3:0] resp_done = '0;
  logic [3:0] man_done  = '0;
  logic [3:0] resp_en   = 4'hF;
  logic       resp_target = 1'b0;
  logic       tgt_pend = 1'b0;
  int         lat_min = 0, lat_max = 0;
  int         pend[4] = '{0, 0, 0, 0};
  int         phase_cycles = 0;
  int         fit_in_run = 0;
  int         es_fit_idx = 0;
  int         n_start[4] = '{0, 0, 0, 0};
  int         n_pli = 0, n_pli_fs = 0, n_plm = 0;
  int         lat_r;

  assign starts = {bus.mut_start, bus.sel_start, bus.fit_start, bus.init_start};
  assign bus.init_done = resp_done[0] | man_done[0];
  assign bus.fit_done  = resp_done[1] | man_done[1];
  assign bus.sel_done  = resp_done[2] | man_done[2];
  assign bus.mut_done  = resp_done[3] | man_done[3];
`ifdef GA_EARLY_STOP_EN
  assign bus.fit_target_met = resp_target;
`endif

  always @(negedge clk) begin
    resp_done   = '0;
    resp_target = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (pend[p] > 0) begin
        pend[p]--;
        if (pend[p] == 0) begin
          resp_done[p] = 1'b1;
          if (p == 1) resp_target = tgt_pend;
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (starts[p]) begin
        n_start[p]++;
        if (p == 0) fit_in_run = 0;
        if (p == 1) fit_in_run++;
        if (resp_en[p]) begin
          lat_r = int'($urandom_range(lat_max, lat_min));
          phase_cycles += lat_r + 1;
          if (p == 1) tgt_pend = (es_fit_idx != 0) && (fit_in_run == es_fit_idx);
          if (lat_r == 0) begin
            resp_done[p] = 1'b1;
            if (p == 1) resp_target = tgt_pend;
          end else begin
            pend[p] = lat_r;
          end
        end
      end
    end
    if (bus.pop_load_init) n_pli++;
    if (bus.pop_load_init && bus.fit_start) n_pli_fs++;
    if (bus.pop_load_mut) n_plm++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    int n = 0;
    while (!(bus.done || bus.error) && n < budget) begin
      tick();
      n++;
    end
    ok = bus.done || bus.error;
  endtask

  // One complete run from go to FINISH, checked against the latency log.
  task automatic run_and_check(input string name, input int lmin, input int lmax,
                               input bit go_in_mut);
    int b_s[4];
    int b_pli, b_pli_fs, b_plm, b_pc, t0, n, dur, exp_dur;
    bit go_sent;
    lat_min = lmin;
    lat_max = lmax;
    for (int p = 0; p < 4; p++) b_s[p] = n_start[p];
    b_pli = n_pli; b_pli_fs = n_pli_fs; b_plm = n_plm; b_pc = phase_cycles;
    pulse_go();
    t0 = cyc;
    checks++;
    if ({bus.init_start, bus.busy, bus.done, bus.error} !== 4'b1100 || bus.gen_count !== '0) begin
      errors++;
      $display("FAIL %s go_entry: start/busy/done/error=%b gen=%0d, want 1100 gen=0",
               name, {bus.init_start, bus.busy, bus.done, bus.error}, bus.gen_count);
    end
    go_sent = 1'b0;
    n = 0;
    while (!(bus.done || bus.error) && n < 2000) begin
      if (go_in_mut && !go_sent && bus.mut_start) begin
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        go_sent = 1'b1;
      end else begin
        tick();
      end
      n++;
    end
    dur = cyc - t0;
    exp_dur = (phase_cycles - b_pc) + NUM_GEN;
    checks++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end_status: done=%b error=%b busy=%b, want 1 0 0",
               name, bus.done, bus.error, bus.busy);
    end
    checks++;
    if (bus.gen_count !== GEN_W'(NUM_GEN)) begin
      errors++;
      $display("FAIL %s gen_count: got %0d want %0d", name, bus.gen_count, NUM_GEN);
    end
    checks++;
    if (n_start[0] - b_s[0] != 1 || n_start[1] - b_s[1] != NUM_GEN ||
        n_start[2] - b_s[2] != NUM_GEN || n_start[3] - b_s[3] != NUM_GEN) begin
      errors++;
      $display("FAIL %s start_counts: got %0d/%0d/%0d/%0d want 1/%0d/%0d/%0d", name,
               n_start[0] - b_s[0], n_start[1] - b_s[1], n_start[2] - b_s[2],
               n_start[3] - b_s[3], NUM_GEN, NUM_GEN, NUM_GEN);
    end
    checks++;
    if (n_pli - b_pli != 1 || n_pli_fs - b_pli_fs != 1 || n_plm - b_plm != NUM_GEN) begin
      errors++;
      $display("FAIL %s load_counts: init=%0d init_with_fit_start=%0d mut=%0d want 1/1/%0d",
               name, n_pli - b_pli, n_pli_fs - b_pli_fs, n_plm - b_plm, NUM_GEN);
    end
    checks++;
    if (dur != exp_dur) begin
      errors++;
      $display("FAIL %s run_cycles: got %0d want %0d", name, dur, exp_dur);
    end
  endtask

  task automatic test_reset();
    bus.go = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({starts, bus.pop_load_init, bus.pop_load_mut, bus.busy, bus.done, bus.error} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000000",
               {starts, bus.pop_load_init, bus.pop_load_mut, bus.busy, bus.done, bus.error});
    end
    checks++;
    if (bus.gen_count !== '0 || bus.err_phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: gen=%0d err_phase=%0d want 0 0", bus.gen_count, bus.err_phase);
    end
  endtask

  task automatic test_full_run();
    run_and_check("full_run_lat5", 5, 5, 1'b0);
  endtask

  task automatic test_zero_latency();
    run_and_check("zero_latency", 0, 0, 1'b0);
  endtask

  task automatic test_random_runs();
    for (int i = 0; i < 3; i++) run_and_check("random_lat", 0, 6, 1'b0);
  endtask

  // Done on the very last watchdog cycle must still be accepted.
  task automatic test_watchdog_boundary();
    run_and_check("done_on_timeout_cycle", TIMEOUT - 1, TIMEOUT - 1, 1'b0);
  endtask

  task automatic test_busy_go();
    run_and_check("go_during_mut", 1, 4, 1'b1);
  endtask

  task automatic test_stray_done();
    int b_sel, b_mut, n;
    bit ok;
    lat_min = 1; lat_max = 3;
    resp_en = 4'b1101;
    pulse_go();
    n = 0;
    while (!bus.fit_start && n < 50) begin tick(); n++; end
    checks++;
    if (bus.fit_start !== 1'b1) begin
      errors++;
      $display("FAIL stray_reach_fit: fit_start=%b want 1", bus.fit_start);
    end
    b_sel = n_start[2]; b_mut = n_start[3];
    tick();
    man_done = 4'b1000;
    tick();
    man_done = 4'b0100;
    tick();
    man_done = 4'b0000;
    tick();
    tick();
    checks++;
    if (n_start[2] != b_sel || n_start[3] != b_mut || bus.busy !== 1'b1 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL stray_ignored: sel_starts+%0d mut_starts+%0d busy=%b error=%b want +0 +0 1 0",
               n_start[2] - b_sel, n_start[3] - b_mut, bus.busy, bus.error);
    end
    man_done = 4'b0010;
    tick();
    man_done = 4'b0000;
    checks++;
    if (bus.sel_start !== 1'b1) begin
      errors++;
      $display("FAIL stray_then_fit_done: sel_start=%b want 1", bus.sel_start);
    end
    resp_en = 4'hF;
    wait_end(2000, ok);
    checks++;
    if (!ok || bus.done !== 1'b1 || bus.gen_count !== GEN_W'(NUM_GEN)) begin
      errors++;
      $display("FAIL stray_run_end: done=%b gen=%0d want 1 %0d", bus.done, bus.gen_count, NUM_GEN);
    end
  endtask

  task automatic test_watchdog();
    int n, t_s, b_tot;
    bit ok;
    for (int p = 0; p < 4; p++) begin
      lat_min = 0; lat_max = 3;
      resp_en = 4'hF & ~(4'b1 << p);
      pulse_go();
      n = 0;
      while (!starts[p] && n < 100) begin tick(); n++; end
      t_s = cyc;
      wait_end(3 * TIMEOUT, ok);
      checks++;
      if (!ok || bus.error !== 1'b1 || cyc - t_s != TIMEOUT) begin
        errors++;
        $display("FAIL watchdog_p%0d_timing: error=%b after %0d cycles want 1 after %0d",
                 p, bus.error, cyc - t_s, TIMEOUT);
      end
      checks++;
      if (bus.err_phase !== 2'(p) || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL watchdog_p%0d_status: err_phase=%0d busy=%b done=%b want %0d 0 0",
                 p, bus.err_phase, bus.busy, bus.done, p);
      end
      b_tot = n_start[0] + n_start[1] + n_start[2] + n_start[3];
      repeat (8) tick();
      checks++;
      if (n_start[0] + n_start[1] + n_start[2] + n_start[3] != b_tot || bus.error !== 1'b1) begin
        errors++;
        $display("FAIL watchdog_p%0d_hold: extra starts=%0d error=%b want 0 1", p,
                 n_start[0] + n_start[1] + n_start[2] + n_start[3] - b_tot, bus.error);
      end
      resp_en = 4'hF;
      run_and_check("restart_after_error", 0, 3, 1'b0);
    end
  endtask

  task automatic test_reset_midrun();
    int n, b_tot;
    lat_min = 2; lat_max = 4;
    pulse_go();
    n = 0;
    while (!(bus.sel_start && bus.gen_count == GEN_W'(3)) && n < 500) begin tick(); n++; end
    checks++;
    if (bus.sel_start !== 1'b1 || bus.gen_count !== GEN_W'(3)) begin
      errors++;
      $display("FAIL midrun_reach_sel_gen3: sel_start=%b gen=%0d want 1 3", bus.sel_start, bus.gen_count);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.gen_count !== '0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_state: busy=%b gen=%0d done=%b error=%b want 0 0 0 0",
               bus.busy, bus.gen_count, bus.done, bus.error);
    end
    rst_n = 1'b1;
    b_tot = n_start[0] + n_start[1] + n_start[2] + n_start[3];
    repeat (12) tick();
    checks++;
    if (n_start[0] + n_start[1] + n_start[2] + n_start[3] != b_tot || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after_reset: extra starts=%0d busy=%b want 0 0",
               n_start[0] + n_start[1] + n_start[2] + n_start[3] - b_tot, bus.busy);
    end
  endtask

`ifdef GA_EARLY_STOP_EN
  task automatic test_early_stop();
    int b_s[4];
    bit ok;
    lat_min = 0; lat_max = 4;
    es_fit_idx = 3;
    for (int p = 0; p < 4; p++) b_s[p] = n_start[p];
    pulse_go();
    wait_end(2000, ok);
    checks++;
    if (!ok || bus.done !== 1'b1 || bus.early_stop !== 1'b1 || bus.gen_count !== GEN_W'(2)) begin
      errors++;
      $display("FAIL early_stop_end: done=%b early_stop=%b gen=%0d want 1 1 2",
               bus.done, bus.early_stop, bus.gen_count);
    end
    checks++;
    if (n_start[1] - b_s[1] != 3 || n_start[2] - b_s[2] != 2 || n_start[3] - b_s[3] != 2) begin
      errors++;
      $display("FAIL early_stop_counts: fit/sel/mut=%0d/%0d/%0d want 3/2/2",
               n_start[1] - b_s[1], n_start[2] - b_s[2], n_start[3] - b_s[3]);
    end
    es_fit_idx = 0;
    pulse_go();
    checks++;
    if (bus.early_stop !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL early_stop_clear_on_go: early_stop=%b done=%b want 0 0", bus.early_stop, bus.done);
    end
    wait_end(2000, ok);
    checks++;
    if (!ok || bus.early_stop !== 1'b0 || bus.gen_count !== GEN_W'(NUM_GEN)) begin
      errors++;
      $display("FAIL early_stop_normal_run: early_stop=%b gen=%0d want 0 %0d",
               bus.early_stop, bus.gen_count, NUM_GEN);
    end
  endtask
`endif

  initial begin
    bus.go = 1'b0;
    test_reset();
    test_full_run();
    test_zero_latency();
    test_random_runs();
    test_watchdog_boundary();
    test_busy_go();
    test_stray_done();
    test_watchdog();
    test_reset_midrun();
`ifdef GA_EARLY_STOP_EN
    test_early_stop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ga_sequencer.md
Name: ga_sequencer

Overview:
- Control-only scheduler for the genetic path-search engine; carries no population data.
- Runs one initial-population phase, then NUM_GEN generations of fitness -> selection -> mutation -> commit.
- Drives one-cycle start pulses to each phase module and consumes their done pulses.
- Drives the load enables on the population register, and provides a per-phase watchdog plus run status.

Parameters:
- NUM_GEN, 100, generations to run after init; legal range 1..2^GEN_W-1.
- GEN_W, 16, width of the generation counter.
- TIMEOUT, 65535, maximum cycles a phase may stay busy before error; legal range 1..2^TO_W-1.
- TO_W, 16, width of the watchdog counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- go  in  1  run request, already one-cycle pulsed upstream; sampled only in IDLE, ERROR, FINISH.
- init_start  out  1  one-cycle start pulse to population initializer.
- init_done  in  1  initializer complete pulse.
- fit_start  out  1  start pulse to fitness evaluator.
- fit_done  in  1  fitness complete pulse.
- sel_start  out  1  start pulse to selection.
- sel_done  in  1  selection complete pulse.
- mut_start  out  1  start pulse to mutation.
- mut_done  in  1  mutation complete pulse.
- pop_load_init  out  1  one-cycle enable: population register <= initializer output.
- pop_load_mut  out  1  one-cycle enable: population register <= mutation output.
- gen_count  out  GEN_W  generations committed this run.
- busy  out  1  high in any state except IDLE, FINISH, ERROR.
- done  out  1  high while in FINISH.
- error  out  1  high while in ERROR.
- err_phase  out  2  phase that timed out: 0 init, 1 fit, 2 sel, 3 mut.

Behaviour:
- Reset (rst_n=0 at posedge) takes priority over every other event, including mid-phase.
- Reset values: state IDLE; all outputs 0; gen_count 0; err_phase 0; watchdog 0.
- States: IDLE, INIT, FIT, SEL, MUT, COMMIT, FINISH, ERROR.
- IDLE/FINISH/ERROR --go--> INIT. On that edge: gen_count <= 0, error clears, done clears.
- Start pulses are registered and asserted for exactly one cycle, the cycle immediately after entering INIT/FIT/SEL/MUT.
- INIT --init_done--> FIT. pop_load_init is asserted for one cycle, coincident with the fit_start cycle.
- FIT --fit_done--> SEL.
- SEL --sel_done--> MUT.
- MUT --mut_done--> COMMIT.
- COMMIT lasts one cycle. In it: pop_load_mut=1 and gen_count increments; the increment is visible the next cycle.
- COMMIT exit:
  - if the incremented gen_count == NUM_GEN, go to FINISH;
  - otherwise go to FIT.
- Done inputs are honoured only in their matching state; a stray or early done (e.g. mut_done while in FIT) is ignored.
- A done arriving in the same cycle as the start pulse is accepted. Minimum phase latency is therefore 1 cycle.
- Watchdog:
  - clears on every phase entry and increments each cycle in INIT/FIT/SEL/MUT;
  - if it reaches TIMEOUT without the matching done, go to ERROR and latch err_phase;
  - a done arriving on the same cycle as the timeout wins, with no error.
- ERROR holds until go or reset; no start pulses are issued while in ERROR.
- go while busy is ignored; there is no restart mid-run.
- gen_count saturates logically: it never exceeds NUM_GEN.

Optional Feature:
- Macro: GA_EARLY_STOP_EN.
- When defined, add input fit_target_met (1 bit), sampled with fit_done.
  - If fit_target_met=1 when fit_done is accepted, go FIT -> FINISH directly; gen_count is unchanged.
  - Add output early_stop (1 bit): set on that transition, cleared by go or reset.
- When undefined:
  - the port does not exist and fit_done always leads to SEL;
  - early_stop is absent.

Test Plan:
- Reset mid-run: drive rst_n=0 while in SEL with gen_count=3 -> next cycle state IDLE, gen_count=0, busy=0, no start pulses afterwards.
- Full run: NUM_GEN=2, each done returned 5 cycles after its start, go pulse ->
  - exactly 1 init_start, 2 fit_start, 2 sel_start, 2 mut_start pulses;
  - 1 pop_load_init and 2 pop_load_mut pulses;
  - ends with done=1, gen_count=2, busy=0.
- Zero-latency phases: each done tied to its own start -> every phase lasts 1 cycle, COMMIT 1 cycle; run completes and gen_count reaches NUM_GEN.
- Stray done: pulse mut_done and sel_done while in FIT -> state stays FIT and no sel_start is issued; a later fit_done -> sel_start.
- Watchdog: TIMEOUT=10, sel_done withheld -> 10 cycles after entering SEL: error=1, err_phase=2, busy=0. A following go restarts from INIT with error=0.
- Busy go / early stop:
  - go during MUT is ignored (pulse counts unchanged);
  - with GA_EARLY_STOP_EN, fit_target_met=1 on the 3rd fit_done -> FINISH, gen_count=2, early_stop=1, no 3rd sel_start.
